store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's memory stage and the 16-bit data memory.
- Accepts stores in one cycle and queues them in a small FIFO.
- Drains one store per cycle to the memory write port whenever the shared memory port is not needed by a load.
- Loads read memory through this block; an address match against a buffered store returns the youngest buffered data instead.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2, 2..16.
- DW, 16, data word width.
- AW, 8, word address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- st_valid  in  1  store request from the memory stage.
- st_addr  in  AW  store word address.
- st_data  in  DW  store data.
- st_ready  out  1  buffer can accept a store this cycle (not full).
- ld_valid  in  1  load request this cycle.
- ld_addr  in  AW  load word address.
- ld_data  out  DW  load result; combinational, same cycle.
- ld_fwd  out  1  ld_data came from the buffer, not memory.
- mem_addr  out  AW  to data memory address port.
- mem_wd  out  DW  to data memory write data.
- mem_we  out  1  to data memory write enable; memory commits on the following negedge.
- mem_rd  in  DW  data memory combinational read data.
- sb_empty  out  1  no stores pending; used by fence/halt logic.

Behaviour:
- State: entry arrays addr/data/valid[DEPTH], head_ptr, tail_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- Reset (rst_n=0 at posedge):
  - head=tail=count=0; all valid bits cleared.
  - Outputs after reset: st_ready=1, sb_empty=1, mem_we=0, ld_fwd=0.
  - Reset mid-operation discards every pending store. No partial drain occurs, since mem_we is gated by count.
- Push:
  - st_ready = (count != DEPTH).
  - On posedge with st_valid && st_ready: write the entry at tail, set valid, tail++.
  - A store with st_valid=1 while full is not accepted; the requester holds it.
  - st_ready does not depend on a same-cycle pop. A full buffer rejects even when draining.
- Drain / port arbitration (combinational):
  - Loads have priority.
  - If ld_valid: mem_addr=ld_addr, mem_we=0.
  - Else if count!=0: mem_addr=addr[head], mem_wd=data[head], mem_we=1.
  - Else: mem_addr=0, mem_wd=0, mem_we=0.
  - On posedge with mem_we=1: clear valid[head], head++.
- Latency:
  - A store pushed at edge N can drain no earlier than the cycle following edge N.
  - Its memory write lands on the negedge of that cycle.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Load forwarding:
  - Scan valid entries from youngest (tail-1) to oldest (head).
  - On the first addr match: ld_data = that entry's data, ld_fwd=1.
  - No match: ld_data=mem_rd, ld_fwd=0.
  - A store offered in the same cycle as a load is not yet buffered and is not forwarded. The pipeline orders these.
  - ld_fwd=0 whenever ld_valid=0.
- sb_empty = (count==0).
- Stores are never merged or reordered; memory sees them in program order.

Decomposition:
- Shared package `sb_pkg`: DW/AW defaults, SB_PTR_W = log2(DEPTH), and the store-entry struct {valid, addr, data}.
- One natural sub-module, `sb_fwd_match`: the priority (youngest-first) address-match search returning hit and data. It is kept separate so it can be verified exhaustively.

Test Plan:
- Reset, then idle: st_ready=1, sb_empty=1, mem_we=0 -> all hold for 10 cycles.
- Push store (0x10, 0xBEEF) with ld_valid=0:
  - next cycle mem_we=1, mem_addr=0x10, mem_wd=0xBEEF;
  - following cycle sb_empty=1;
  - a memory model holds 0xBEEF at 0x10.
- Hold ld_valid=1 while pushing 4 stores to 0x01..0x04:
  - st_ready=0 after the 4th; a 5th store is held;
  - release the load -> drains in order 0x01, 0x02, 0x03, 0x04 on consecutive cycles;
  - the 5th is accepted once count<4.
- Buffer stores (0x20, 0x1111) then (0x20, 0x2222) with draining blocked; load 0x20 -> ld_data=0x2222, ld_fwd=1.
- Load 0x30 with no buffered match, mem_rd=0xCAFE -> ld_data=0xCAFE, ld_fwd=0.
- Fill 3 entries, assert rst_n=0 for one cycle -> sb_empty=1, mem_we=0, and no writes reach memory afterward.
- Wrap-around: 10 push/drain pairs -> pointers wrap and FIFO order is preserved.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the posted-write store buffer.
// Entry widths track the package defaults.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_DW    = 16;
  localparam int SB_AW    = 8;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match over the buffered stores.
// Scans oldest to youngest so the youngest hit overwrites older ones.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                    en,
  input  logic [SB_AW-1:0]        addr,
  input  sb_entry_t [DEPTH-1:0]   ents,
  input  logic [PW-1:0]           head,
  input  logic [PW:0]             count,
  output logic                    hit,
  output logic [SB_DW-1:0]        data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (en && ((PW+1)'(i) < count) &&
          ents[idx].valid &&
          ents[idx].addr == addr) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of the data memory port.
// Loads own the port; stores drain one per idle cycle.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int DW    = SB_DW,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_fwd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          sb_empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] ents_q, ents_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          push, pop;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign st_ready = (count_q != (PW+1)'(DEPTH));
  assign sb_empty = (count_q == '0);
  assign push     = st_valid && st_ready;
  assign pop      = !ld_valid && !sb_empty;

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (!sb_empty) begin
      mem_addr = ents_q[head_q].addr;
      mem_wd   = ents_q[head_q].data;
      mem_we   = 1'b1;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .en    (ld_valid),
    .addr  (ld_addr),
    .ents  (ents_q),
    .head  (head_q),
    .count (count_q),
    .hit   (hit),
    .data  (hit_data)
  );

  assign ld_fwd  = hit;
  assign ld_data = hit ? hit_data : mem_rd;

  always_comb begin
    ents_d  = ents_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      ents_d[head_q].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    // a full buffer never pushes, so tail cannot alias a popping head
    if (push) begin
      ents_d[tail_q] = '{valid: 1'b1, addr: st_addr, data: st_data};
      tail_d = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ents_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ents_q  <= ents_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a negedge-commit memory model.
// Inputs change 1ns after posedge; outputs are checked mid-cycle.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [7:0]  st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_fwd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wd;
  logic        mem_we;
  logic [15:0] mem_rd;
  logic        sb_empty;

  logic [15:0] mem [256];
  bit          mem_init;
  int          checks;
  int          failures;

  store_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_fwd   (ld_fwd),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .sb_empty (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h30] <= 16'hCAFE;
      mem_init   <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
  end

  assign mem_rd = mem[mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", sb_empty, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_fwd", ld_fwd, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {st_ready, sb_empty, mem_we}, 3'b110);
    end

    // single store drains next cycle
    st_valid = 1'b1; st_addr = 8'h10; st_data = 16'hBEEF;
    step();
    st_valid = 1'b0;
    #1;
    chk("d1_we", mem_we, 1);
    chk("d1_addr", mem_addr, 8'h10);
    chk("d1_wd", mem_wd, 16'hBEEF);
    step();
    chk("d1_empty", sb_empty, 1);
    chk("d1_we0", mem_we, 0);
    chk("d1_mem", mem[8'h10], 16'hBEEF);

    // fill while a load blocks the port
    ld_valid = 1'b1; ld_addr = 8'h80;
    for (int i = 1; i <= 4; i++) begin
      st_valid = 1'b1; st_addr = 8'(i); st_data = 16'(16'h0100 + i);
      #1;
      chk("fill_ready", st_ready, 1);
      step();
    end
    st_addr = 8'h05; st_data = 16'h0105;
    #1;
    chk("full_ready", st_ready, 0);
    chk("full_we", mem_we, 0);
    chk("full_nofwd", ld_fwd, 0);
    step();
    chk("held_ready", st_ready, 0);
    ld_valid = 1'b0;
    #1;
    chk("dr_we", mem_we, 1);
    chk("dr_a1", mem_addr, 8'h01);
    chk("dr_full", st_ready, 0);
    step();
    chk("dr_a2", mem_addr, 8'h02);
    chk("dr_ready", st_ready, 1);
    step();
    st_valid = 1'b0;
    #1;
    chk("dr_a3", mem_addr, 8'h03);
    step();
    chk("dr_a4", mem_addr, 8'h04);
    step();
    chk("dr_a5", mem_addr, 8'h05);
    chk("dr_wd5", mem_wd, 16'h0105);
    step();
    chk("dr_empty", sb_empty, 1);
    for (int i = 1; i <= 5; i++)
      chk("dr_mem", mem[i], 32'(16'h0100 + i));

    // forwarding picks the youngest match
    ld_valid = 1'b1; ld_addr = 8'h20;
    st_valid = 1'b1; st_addr = 8'h20; st_data = 16'h1111;
    step();
    st_data = 16'h2222;
    step();
    st_valid = 1'b0;
    #1;
    chk("fwd_data", ld_data, 16'h2222);
    chk("fwd_hit", ld_fwd, 1);
    ld_addr = 8'h30;
    #1;
    chk("miss_data", ld_data, 16'hCAFE);
    chk("miss_fwd", ld_fwd, 0);
    ld_valid = 1'b0; ld_addr = 8'h20;
    #1;
    chk("nold_fwd", ld_fwd, 0);
    chk("fd_addr", mem_addr, 8'h20);
    chk("fd_wd1", mem_wd, 16'h1111);
    step();
    chk("fd_wd2", mem_wd, 16'h2222);
    step();
    chk("fd_empty", sb_empty, 1);
    chk("fd_mem", mem[8'h20], 16'h2222);

    // reset discards pending stores
    ld_valid = 1'b1; ld_addr = 8'h80;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 8'(8'h40 + i); st_data = 16'(16'hAAA0 + i);
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("pre_rst_empty", sb_empty, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; ld_valid = 1'b0;
    #1;
    chk("rst2_empty", sb_empty, 1);
    chk("rst2_we", mem_we, 0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 3; i++)
      chk("rst2_mem", mem[8'h40 + i], 0);

    // streaming push/drain across pointer wrap
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_addr = 8'(8'h60 + i); st_data = 16'(16'h5000 + i);
      #1;
      if (i > 0) begin
        chk("wr_addr", mem_addr, 32'(8'h60 + i - 1));
        chk("wr_wd", mem_wd, 32'(16'h5000 + i - 1));
      end
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("wr_last", mem_addr, 8'h69);
    step();
    chk("wr_empty", sb_empty, 1);
    for (int i = 0; i < 10; i++)
      chk("wr_mem", mem[8'h60 + i], 32'(16'h5000 + i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
